word_align: RTL and testbench
=============================

// Module: word_align
// PURPOSE
//  Upstream neighbour of the PRBS word checker. Takes raw, arbitrarily bit-shifted
//  16-bit deserializer words and searches all 16 bit offsets for SYNC_WORD. It locks
//  the offset once frame structure is confirmed, then emits realigned words.
//  Outputs ALIGNED/DOPUSH/DOUT/INIT drive the checker's ALIGNED/DIPUSH/DIN/INIT inputs.
//  Frame on the wire: one SYNC_WORD followed by FRAME_LEN payload words.
// PARAMETERS
//  SYNC_WORD   16'hB4C3  frame marker; compared at every candidate bit offset
//  FRAME_LEN   1024      payload words between consecutive sync words (>=2)
//  LOCK_CNT    4         consecutive sync hits, first one included, required to lock
//  UNLOCK_CNT  4         consecutive sync misses while LOCKED that drop lock
// PORTS
//  CLK       in   1   clock
//  RSTX      in   1   asynchronous active-low reset
//  CLR       in   1   synchronous clear; same effect as reset
//  RAW_PUSH  in   1   RAW valid this cycle; may be gapped arbitrarily
//  RAW       in   16  raw deserialized word; MSB is the earliest bit on the wire
//  DOPUSH    out  1   DOUT valid; pulses once per accepted RAW_PUSH outside HUNT
//  DOUT      out  16  realigned word
//  ALIGNED   out  1   high in LOCKED
//  INIT      out  1   1-cycle pulse with the DOPUSH of each matched sync word in LOCKED
//  OFFSET    out  4   current bit offset k (0..15)
//  LOSS_CNT  out  16  count of LOCKED->HUNT transitions; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset/CLR: state=HUNT, all outputs 0, raw_d1=0, raw_v=0, all counters 0.
//  CLR takes priority over every other event in the same cycle.
//  Window: on each RAW_PUSH, cat={raw_d1,RAW} (32b) and win(k)=cat[31-k -: 16].
//   raw_d1 <= RAW and raw_v <= 1 on every push. Nothing changes on cycles without RAW_PUSH.
//  Outputs are registered, 1-cycle latency: the push at edge t drives DOPUSH/DOUT/INIT/ALIGNED at t+1.
//  wcnt counts payload pushes since the last expected sync position (0..FRAME_LEN).
//   A push is at the sync position when wcnt==FRAME_LEN; wcnt then reloads to 0.
//  HUNT: DOPUSH=0, ALIGNED=0. On a push with raw_v=1, scan k=0..15; the lowest k with
//   win(k)==SYNC_WORD wins. On a hit: OFFSET<=k, wcnt<=0, hits<=1, go VERIFY
//   (if LOCK_CNT==1 go directly LOCKED, emitting INIT). On no hit, stay.
//  VERIFY: DOPUSH=1 per push, DOUT=win(OFFSET), ALIGNED=0, INIT=0.
//   At the sync position: a match does hits+1; when hits reaches LOCK_CNT go LOCKED,
//   and that same sync word's output has ALIGNED=1 and INIT=1. A mismatch goes to HUNT
//   with DOPUSH=0 for that push; this cycle is not rescanned.
//  LOCKED: DOPUSH=1 per push, ALIGNED=1. At the sync position: a match clears miss and
//   pulses INIT. A mismatch does miss+1 with no INIT (the checker skips that frame), and
//   the flywheel keeps wcnt running. When miss reaches UNLOCK_CNT go HUNT, ALIGNED=0 and
//   DOPUSH=0 from that push, LOSS_CNT+1 (saturating). OFFSET holds in LOCKED.
//  Payload equal to SYNC_WORD off the sync position is ignored outside HUNT.
//  Async reset mid-frame drops outputs at once. The next lock needs LOCK_CNT fresh syncs.
// TESTING
//  1 Offset 5 stream, frames of SYNC+1024 LFSR words -> VERIFY after sync#1, ALIGNED rises
//    with DOPUSH of sync#4, INIT=1, DOUT=16'hB4C3, OFFSET=5, next 1024 DOUT equal payload.
//  2 Locked, corrupt syncs #5..#7 -> ALIGNED stays 1, no INIT on those frames, LOSS_CNT=0;
//    sync #8 matches -> INIT again. Corrupting #5..#8 -> ALIGNED=0 after #8, LOSS_CNT=1.
//  3 Corrupt sync#3 in VERIFY -> HUNT, ALIGNED never rises; 4 clean syncs relock.
//  4 Repeat 1 with RAW_PUSH 50% random gaps -> identical DOUT sequence and lock point.
//  5 Sync matches at offsets 3 and 11 in one window -> OFFSET=3 chosen.
//  6 CLR or RSTX low mid-frame while locked -> all outputs 0 next edge/immediately; relock
//    occurs on the 4th sync after release.

Source files
------------

// File: rtl/word_align.sv
// word_align: finds SYNC_WORD at any of 16 bit offsets in a raw 16-bit word
// stream, locks the offset after LOCK_CNT framed hits, then emits realigned words.
//
// Ports:
//   CLK, RSTX (async active-low), CLR (sync clear)
//   RAW_PUSH/RAW      : raw deserializer word in (MSB earliest on the wire)
//   DOPUSH/DOUT       : realigned word out, one pulse per accepted push outside HUNT
//   ALIGNED           : high while LOCKED
//   INIT              : pulses with the DOPUSH of each matched sync word while LOCKED
//   OFFSET            : current bit offset
//   LOSS_CNT          : saturating count of LOCKED->HUNT transitions
module word_align #(
    parameter logic [15:0] SYNC_WORD  = 16'hB4C3,
    parameter int          FRAME_LEN  = 1024,
    parameter int          LOCK_CNT   = 4,
    parameter int          UNLOCK_CNT = 4
) (
    input  logic        CLK,
    input  logic        RSTX,
    input  logic        CLR,
    input  logic        RAW_PUSH,
    input  logic [15:0] RAW,
    output logic        DOPUSH,
    output logic [15:0] DOUT,
    output logic        ALIGNED,
    output logic        INIT,
    output logic [3:0]  OFFSET,
    output logic [15:0] LOSS_CNT
);
    localparam int WW = $clog2(FRAME_LEN + 1);
    localparam int HW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);

    localparam logic [WW-1:0] WLAST = WW'(FRAME_LEN);
    localparam logic [HW-1:0] HLOCK = HW'(LOCK_CNT);
    localparam logic [MW-1:0] MDROP = MW'(UNLOCK_CNT);

    localparam logic [1:0] S_HUNT   = 2'd0;
    localparam logic [1:0] S_VERIFY = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [15:0]   raw_q, raw_d;
    logic          rawv_q, rawv_d;
    logic [3:0]    off_q, off_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [HW-1:0] hits_q, hits_d;
    logic [MW-1:0] miss_q, miss_d;
    logic          dopush_q, dopush_d;
    logic [15:0]   dout_q, dout_d;
    logic          aligned_q, aligned_d;
    logic          init_q, init_d;
    logic [15:0]   loss_q, loss_d;

    logic [31:0]   cat;
    logic [15:0]   win_cur;
    logic          scan_hit;
    logic [3:0]    scan_k;
    logic          sync_pos;
    logic [WW-1:0] wcnt_nx;
    logic [HW-1:0] hits_nx;
    logic [MW-1:0] miss_nx;

    // win(k) = cat[31-k -: 16], written as a shift so k can be a signal
    function automatic logic [15:0] win_at(input logic [31:0] c,
                                           input logic [3:0]  k);
        return 16'(c >> (5'd16 - {1'b0, k}));
    endfunction

    assign cat      = {raw_q, RAW};
    assign win_cur  = win_at(cat, off_q);
    assign sync_pos = (wcnt_q == WLAST);
    assign wcnt_nx  = sync_pos ? '0 : wcnt_q + WW'(1);
    assign hits_nx  = hits_q + HW'(1);
    assign miss_nx  = miss_q + MW'(1);

    // Descending scan so the lowest matching offset is the one kept
    always_comb begin
        scan_hit = 1'b0;
        scan_k   = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (win_at(cat, 4'(k)) == SYNC_WORD) begin
                scan_hit = 1'b1;
                scan_k   = 4'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        raw_d     = raw_q;
        rawv_d    = rawv_q;
        off_d     = off_q;
        wcnt_d    = wcnt_q;
        hits_d    = hits_q;
        miss_d    = miss_q;
        dopush_d  = 1'b0;
        dout_d    = dout_q;
        aligned_d = aligned_q;
        init_d    = 1'b0;
        loss_d    = loss_q;
        if (RAW_PUSH) begin
            raw_d  = RAW;
            rawv_d = 1'b1;
            unique case (state_q)
                S_HUNT: begin
                    aligned_d = 1'b0;
                    if (rawv_q && scan_hit) begin
                        off_d  = scan_k;
                        wcnt_d = '0;
                        hits_d = HW'(1);
                        miss_d = '0;
                        if (LOCK_CNT == 1) begin
                            state_d   = S_LOCKED;
                            dopush_d  = 1'b1;
                            dout_d    = win_at(cat, scan_k);
                            aligned_d = 1'b1;
                            init_d    = 1'b1;
                        end else begin
                            state_d = S_VERIFY;
                        end
                    end
                end
                S_VERIFY: begin
                    wcnt_d    = wcnt_nx;
                    dopush_d  = 1'b1;
                    dout_d    = win_cur;
                    aligned_d = 1'b0;
                    if (sync_pos) begin
                        if (win_cur == SYNC_WORD) begin
                            hits_d = hits_nx;
                            if (hits_nx == HLOCK) begin
                                state_d   = S_LOCKED;
                                aligned_d = 1'b1;
                                init_d    = 1'b1;
                                miss_d    = '0;
                            end
                        end else begin
                            // framing broken before lock: drop this word too
                            state_d  = S_HUNT;
                            dopush_d = 1'b0;
                        end
                    end
                end
                S_LOCKED: begin
                    wcnt_d    = wcnt_nx;
                    dopush_d  = 1'b1;
                    dout_d    = win_cur;
                    aligned_d = 1'b1;
                    if (sync_pos) begin
                        if (win_cur == SYNC_WORD) begin
                            miss_d = '0;
                            init_d = 1'b1;
                        end else begin
                            // flywheel: keep counting, skip INIT for this frame
                            miss_d = miss_nx;
                            if (miss_nx == MDROP) begin
                                state_d   = S_HUNT;
                                dopush_d  = 1'b0;
                                aligned_d = 1'b0;
                                if (loss_q != 16'hFFFF) begin
                                    loss_d = loss_q + 16'd1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d   = S_HUNT;
                    aligned_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q   <= S_HUNT;
            raw_q     <= '0;
            rawv_q    <= 1'b0;
            off_q     <= '0;
            wcnt_q    <= '0;
            hits_q    <= '0;
            miss_q    <= '0;
            dopush_q  <= 1'b0;
            dout_q    <= '0;
            aligned_q <= 1'b0;
            init_q    <= 1'b0;
            loss_q    <= '0;
        end else if (CLR) begin
            state_q   <= S_HUNT;
            raw_q     <= '0;
            rawv_q    <= 1'b0;
            off_q     <= '0;
            wcnt_q    <= '0;
            hits_q    <= '0;
            miss_q    <= '0;
            dopush_q  <= 1'b0;
            dout_q    <= '0;
            aligned_q <= 1'b0;
            init_q    <= 1'b0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            raw_q     <= raw_d;
            rawv_q    <= rawv_d;
            off_q     <= off_d;
            wcnt_q    <= wcnt_d;
            hits_q    <= hits_d;
            miss_q    <= miss_d;
            dopush_q  <= dopush_d;
            dout_q    <= dout_d;
            aligned_q <= aligned_d;
            init_q    <= init_d;
            loss_q    <= loss_d;
        end
    end

    assign DOPUSH   = dopush_q;
    assign DOUT     = dout_q;
    assign ALIGNED  = aligned_q;
    assign INIT     = init_q;
    assign OFFSET   = off_q;
    assign LOSS_CNT = loss_q;

endmodule

// File: tb/tb_word_align.sv
// tb_word_align: random framed bit streams at chosen offsets, scored against
// a bit-level reference model through an expected-output queue.
module tb_word_align;
    localparam logic [15:0] SYNC = 16'hB4C3;
    localparam int FL = 32;
    localparam int LK = 4;
    localparam int UL = 4;
    localparam int MH = 0;
    localparam int MV = 1;
    localparam int ML = 2;

    logic        CLK = 1'b0;
    logic        RSTX = 1'b0;
    logic        CLR = 1'b0;
    logic        RAW_PUSH = 1'b0;
    logic [15:0] RAW = '0;
    logic        DOPUSH;
    logic [15:0] DOUT;
    logic        ALIGNED;
    logic        INIT;
    logic [3:0]  OFFSET;
    logic [15:0] LOSS_CNT;

    logic        p_push = 1'b0;
    logic [15:0] p_raw = '0;
    logic        p_dopush;
    logic [15:0] p_dout;
    logic        p_aligned;
    logic        p_init;
    logic [3:0]  p_off;
    logic [15:0] p_loss;

    always #5 CLK = ~CLK;

    word_align #(.SYNC_WORD(SYNC), .FRAME_LEN(FL),
                 .LOCK_CNT(LK), .UNLOCK_CNT(UL)) dut (
        .CLK(CLK), .RSTX(RSTX), .CLR(CLR),
        .RAW_PUSH(RAW_PUSH), .RAW(RAW),
        .DOPUSH(DOPUSH), .DOUT(DOUT), .ALIGNED(ALIGNED),
        .INIT(INIT), .OFFSET(OFFSET), .LOSS_CNT(LOSS_CNT)
    );

    // periodic sync word so two offsets can match in one window
    word_align #(.SYNC_WORD(16'hC3C3), .FRAME_LEN(4),
                 .LOCK_CNT(4), .UNLOCK_CNT(4)) u_p (
        .CLK(CLK), .RSTX(RSTX), .CLR(CLR),
        .RAW_PUSH(p_push), .RAW(p_raw),
        .DOPUSH(p_dopush), .DOUT(p_dout), .ALIGNED(p_aligned),
        .INIT(p_init), .OFFSET(p_off), .LOSS_CNT(p_loss)
    );

    typedef struct packed {
        logic [15:0] dout;
        logic        init;
        logic        aligned;
        logic [3:0]  off;
        logic [15:0] loss;
    } ev_t;

    ev_t expq[$];
    ev_t mon_e;
    int  vec = 0;
    int  mis = 0;

    bit  wb[$];
    int  wp = 0;

    int  dop_cnt = 0;
    int  ini_cnt = 0;
    int  al_cnt = 0;
    int  init_at[$];

    int  m_mode, m_k, m_phase, m_good, m_bad, m_loss;
    bit  m_rv;

    int  b_dop, b_ini, b_al;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] bits_at(input int s);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[15-i] = wb[s+i];
        return r;
    endfunction

    function automatic int lock_point(input int bi, input int bd);
        if (init_at.size() > bi) return init_at[bi] - bd;
        return -1;
    endfunction

    task automatic append_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) wb.push_back(w[i]);
    endtask

    task automatic gen_frame(input bit bad);
        append_word(bad ? (SYNC ^ 16'h0010) : SYNC);
        repeat (FL) append_word(16'($urandom));
    endtask

    task automatic start_stream(input int k);
        while (wb.size() % 16 != 0) wb.push_back(1'($urandom_range(0, 1)));
        repeat (k) wb.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic model_clear();
        m_mode = MH; m_k = 0; m_phase = 0;
        m_good = 0; m_bad = 0; m_loss = 0; m_rv = 0;
    endtask

    // Reference: word n of the wire holds bits 16n..16n+15; the window for
    // offset k at push n starts at bit 16(n-1)+k.
    task automatic model_push(input int n);
        logic [15:0] w;
        bit at, emit, ini, al, found;
        if (m_mode == MH) begin
            found = 0;
            if (m_rv) begin
                for (int k = 0; k < 16; k++) begin
                    if (!found && bits_at(16*(n-1)+k) == SYNC) begin
                        found = 1; m_k = k;
                    end
                end
            end
            if (found) begin
                m_mode = MV; m_phase = 0; m_good = 1;
            end
        end else begin
            w = bits_at(16*(n-1)+m_k);
            at = (m_phase == FL);
            m_phase = at ? 0 : m_phase + 1;
            emit = 1; ini = 0; al = (m_mode == ML);
            if (at && m_mode == MV) begin
                if (w == SYNC) begin
                    m_good++;
                    if (m_good == LK) begin
                        m_mode = ML; m_bad = 0; al = 1; ini = 1;
                    end
                end else begin
                    m_mode = MH; emit = 0;
                end
            end else if (at) begin
                if (w == SYNC) begin
                    m_bad = 0; ini = 1;
                end else begin
                    m_bad++;
                    if (m_bad == UL) begin
                        m_mode = MH; emit = 0;
                        if (m_loss < 65535) m_loss++;
                    end
                end
            end
            if (emit) expq.push_back('{w, ini, al, 4'(m_k), 16'(m_loss)});
        end
        m_rv = 1;
    endtask

    task automatic push_all(input bit gaps, input int keep);
        int g;
        while (wb.size() >= 16*(wp+1) + 16*keep) begin
            g = 0;
            while (gaps && $urandom_range(0, 1) == 0 && g < 6) begin
                @(negedge CLK);
                RAW_PUSH = 1'b0;
                RAW = 16'($urandom);
                g++;
            end
            @(negedge CLK);
            RAW_PUSH = 1'b1;
            RAW = bits_at(16*wp);
            model_push(wp);
            wp++;
        end
        @(negedge CLK);
        RAW_PUSH = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic do_clr();
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        model_clear();
    endtask

    task automatic mark();
        b_dop = dop_cnt; b_ini = ini_cnt; b_al = al_cnt;
    endtask

    initial begin
        model_clear();
        fork
            forever begin
                @(negedge CLK);
                if (DOPUSH === 1'b1) begin
                    dop_cnt++;
                    if (INIT === 1'b1) begin
                        ini_cnt++;
                        init_at.push_back(dop_cnt);
                    end
                    if (ALIGNED === 1'b1) al_cnt++;
                    if (expq.size() == 0) begin
                        vec++; mis++;
                        $display("FAIL unexpected_dopush: got DOUT=%0h want none",
                                 DOUT);
                    end else begin
                        mon_e = expq.pop_front();
                        chk("dout", 32'(DOUT), 32'(mon_e.dout));
                        chk("init", 32'(INIT), 32'(mon_e.init));
                        chk("aligned", 32'(ALIGNED), 32'(mon_e.aligned));
                        chk("offset", 32'(OFFSET), 32'(mon_e.off));
                        chk("loss", 32'(LOSS_CNT), 32'(mon_e.loss));
                    end
                end
            end
        join_none

        repeat (3) @(negedge CLK);
        chk("rst_dopush", 32'(DOPUSH), 0);
        chk("rst_dout", 32'(DOUT), 0);
        chk("rst_aligned", 32'(ALIGNED), 0);
        chk("rst_init", 32'(INIT), 0);
        chk("rst_offset", 32'(OFFSET), 0);
        chk("rst_loss", 32'(LOSS_CNT), 0);
        RSTX = 1'b1;

        // clean stream at offset 5
        do_clr();
        start_stream(5);
        mark();
        repeat (4) gen_frame(0);
        push_all(0, 0);
        chk("t1_inits", 32'(ini_cnt - b_ini), 1);
        chk("t1_lock_point", 32'(lock_point(b_ini, b_dop)), 3*(FL+1));
        chk("t1_aligned", 32'(ALIGNED), 1);
        chk("t1_offset", 32'(OFFSET), 5);
        chk("t1_loss", 32'(LOSS_CNT), 0);
        gen_frame(0);
        push_all(0, 0);
        chk("t1_inits2", 32'(ini_cnt - b_ini), 2);

        // flywheel through three bad syncs, then lose lock on four
        mark();
        repeat (3) gen_frame(1);
        gen_frame(0);
        push_all(0, 0);
        chk("t2_aligned", 32'(ALIGNED), 1);
        chk("t2_loss0", 32'(LOSS_CNT), 0);
        chk("t2_inits", 32'(ini_cnt - b_ini), 1);
        repeat (4) gen_frame(1);
        push_all(0, 0);
        chk("t2_unlocked", 32'(ALIGNED), 0);
        chk("t2_loss1", 32'(LOSS_CNT), 1);

        // bad sync while verifying, then relock at offset 9
        do_clr();
        start_stream(9);
        mark();
        repeat (2) gen_frame(0);
        gen_frame(1);
        repeat (3) gen_frame(0);
        push_all(0, 0);
        chk("t3_never_aligned", 32'(al_cnt - b_al), 0);
        chk("t3_aligned0", 32'(ALIGNED), 0);
        gen_frame(0);
        push_all(0, 0);
        chk("t3_relock", 32'(ALIGNED), 1);
        chk("t3_offset", 32'(OFFSET), 9);

        // two offsets match in one window: lowest wins
        do_clr();
        @(negedge CLK);
        p_push = 1'b1;
        p_raw = 16'h1878;
        @(negedge CLK);
        p_raw = 16'h7860;
        @(negedge CLK);
        p_push = 1'b0;
        chk("t5_offset", 32'(p_off), 3);
        chk("t5_no_dopush", 32'(p_dopush), 0);

        // gapped input gives the same lock point
        do_clr();
        start_stream(5);
        mark();
        repeat (5) gen_frame(0);
        push_all(1, 0);
        chk("t4_lock_point", 32'(lock_point(b_ini, b_dop)), 3*(FL+1));
        chk("t4_inits", 32'(ini_cnt - b_ini), 2);
        chk("t4_offset", 32'(OFFSET), 5);
        chk("t4_aligned", 32'(ALIGNED), 1);

        // CLR mid-frame while locked
        gen_frame(0);
        push_all(0, 10);
        chk("t6_pre_aligned", 32'(ALIGNED), 1);
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        chk("t6_clr_aligned", 32'(ALIGNED), 0);
        chk("t6_clr_offset", 32'(OFFSET), 0);
        chk("t6_clr_dout", 32'(DOUT), 0);
        CLR = 1'b0;
        model_clear();
        mark();
        repeat (4) gen_frame(0);
        push_all(0, 10);
        chk("t6_clr_lock_point", 32'(lock_point(b_ini, b_dop)), 3*(FL+1));
        chk("t6_clr_relock", 32'(ALIGNED), 1);

        // async reset mid-frame while locked, away from the clock edge
        @(negedge CLK);
        #2 RSTX = 1'b0;
        #1;
        chk("t6_rst_aligned", 32'(ALIGNED), 0);
        chk("t6_rst_dout", 32'(DOUT), 0);
        chk("t6_rst_offset", 32'(OFFSET), 0);
        @(negedge CLK);
        RSTX = 1'b1;
        model_clear();
        mark();
        repeat (4) gen_frame(0);
        push_all(0, 0);
        chk("t6_rst_lock_point", 32'(lock_point(b_ini, b_dop)), 3*(FL+1));
        chk("t6_rst_relock", 32'(ALIGNED), 1);

        repeat (4) @(negedge CLK);
        chk("queue_drained", 32'(expq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
